// File: rtl/drawbridge_pkg.sv
// Purpose : shared types and default parameters for the drawbridge controller.
// Latency : n/a (types and constants only).
// Flow    : n/a.
// Contents: state_t (3-bit FSM encoding), default parameter constants.
package drawbridge_pkg;

  typedef enum logic [2:0] {
    FLAT     = 3'd0,
    CLEARING = 3'd1,
    LIFTING  = 3'd2,
    UPRIGHT  = 3'd3,
    LOWERING = 3'd4,
    FAULT    = 3'd5
  } state_t;

  localparam int DEF_N_LEAVES     = 2;
  localparam int DEF_CLEAR_CYCLES = 16;
  localparam int DEF_MOVE_TIMEOUT = 1000;
  localparam int DEF_HOLD_CYCLES  = 64;

endpackage

// File: rtl/drawbridge_leaf_drv.sv
// Purpose : per-leaf motor gating against its own limit switches, plus sensor-conflict detect.
// Latency : combinational; the controller registers the results.
// Flow    : no handshake; a leaf stops driving once its limit switch is reached.
// Ports   : i_move_up/i_move_dn (controller direction), i_h/i_l (limit switches),
//           o_mup/o_mdn (gated motor commands), o_conflict (both limits active).
module drawbridge_leaf_drv
  import drawbridge_pkg::*;
(
  input  logic i_move_up,
  input  logic i_move_dn,
  input  logic i_h,
  input  logic i_l,
  output logic o_mup,
  output logic o_mdn,
  output logic o_conflict
);

  // Each direction is also masked by the other so both motors can never run together.
  assign o_mup      = i_move_up & ~i_move_dn & ~i_h;
  assign o_mdn      = i_move_dn & ~i_move_up & ~i_l;
  assign o_conflict = i_h & i_l;

endmodule

// File: rtl/drawbridge_ctrl_multi.sv
// Purpose : multi-leaf drawbridge controller (clearing interval, travel timeout, sensor fault, boat reversal).
// Latency : all outputs registered; they reflect the state entered at the same clock edge.
// Flow    : CIB=1 pauses motion (motors off, timer frozen); FAULT holds until Reset.
// Ports   : Clock, Reset (async active-low), CIB, MD, PB, BS, H[N], L[N] in;
//           MUP[N], MDN[N], AL, TFL, FLT out.
// Config  : define DRAWBRIDGE_HOLD_EN to enforce a HOLD_CYCLES minimum dwell in UPRIGHT.
module drawbridge_ctrl_multi
  import drawbridge_pkg::*;
#(
  parameter int N_LEAVES     = DEF_N_LEAVES,
  parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES,
  parameter int MOVE_TIMEOUT = DEF_MOVE_TIMEOUT,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                CIB,
  input  logic                MD,
  input  logic                PB,
  input  logic                BS,
  input  logic [N_LEAVES-1:0] H,
  input  logic [N_LEAVES-1:0] L,
  output logic [N_LEAVES-1:0] MUP,
  output logic [N_LEAVES-1:0] MDN,
  output logic                AL,
  output logic                TFL,
  output logic                FLT
);

  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
  localparam int MOV_W = $clog2(MOVE_TIMEOUT + 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [MOV_W-1:0] MOV_LAST = MOV_W'(MOVE_TIMEOUT - 1);
  localparam logic [MOV_W-1:0] MOV_MAX  = MOV_W'(MOVE_TIMEOUT);

  state_t              r_state;
  state_t              w_nxt;
  logic [CLR_W-1:0]    r_clr_cnt;
  logic [MOV_W-1:0]    r_mov_cnt;
  logic                r_pb_q;
  logic                r_al, r_tfl, r_flt;
  logic [N_LEAVES-1:0] r_mup, r_mdn;

  logic                w_pb_edge, w_lift_req, w_lower_req;
  logic                w_all_h, w_all_l, w_any_conflict, w_hold_ok;
  logic                w_move_up, w_move_dn;
  logic [N_LEAVES-1:0] w_mup, w_mdn, w_conflict;

  assign w_pb_edge      = PB & ~r_pb_q;
  assign w_lift_req     = MD ? w_pb_edge : BS;
  assign w_lower_req    = MD ? w_pb_edge : ~BS;
  assign w_all_h        = &H;
  assign w_all_l        = &L;
  assign w_any_conflict = |w_conflict;

`ifdef DRAWBRIDGE_HOLD_EN
  localparam int HLD_W = $clog2(HOLD_CYCLES + 1);
  logic [HLD_W-1:0] r_hold_cnt;

  // Counts UPRIGHT dwell; any state change (including entry) restarts it.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_hold_cnt <= '0;
    end else if (w_nxt != r_state || r_state != UPRIGHT) begin
      r_hold_cnt <= '0;
    end else if (r_hold_cnt != HLD_W'(HOLD_CYCLES)) begin
      r_hold_cnt <= r_hold_cnt + HLD_W'(1);
    end
  end

  assign w_hold_ok = (r_hold_cnt == HLD_W'(HOLD_CYCLES));
`else
  // No dwell requirement; HOLD_CYCLES is non-negative so this is always 1.
  assign w_hold_ok = (HOLD_CYCLES >= 0);
`endif

  // Next-state decision. The conflict override is applied last so it beats every transition.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      FLAT: begin
        if (w_lift_req)    w_nxt = CLEARING;
        else if (!w_all_l) w_nxt = LOWERING;   // leaves not down after reset: bring them home
      end
      CLEARING: begin
        if (!CIB && r_clr_cnt == CLR_LAST) w_nxt = LIFTING;
      end
      LIFTING: begin
        // Completion is checked before timeout so a tie finishes the move.
        if (!CIB) begin
          if (w_all_h)                    w_nxt = UPRIGHT;
          else if (r_mov_cnt == MOV_LAST) w_nxt = FAULT;
        end
      end
      UPRIGHT: begin
        if (w_lower_req && !CIB && w_hold_ok) w_nxt = LOWERING;
      end
      LOWERING: begin
        if (!CIB) begin
          if (w_all_l)                    w_nxt = FLAT;
          else if (!MD && BS)             w_nxt = LIFTING;
          else if (r_mov_cnt == MOV_LAST) w_nxt = FAULT;
        end
      end
      FAULT:   w_nxt = FAULT;
      default: w_nxt = FAULT;
    endcase
    if (w_any_conflict) w_nxt = FAULT;
  end

  // Motor direction follows the state being entered; a car on the deck stops both.
  assign w_move_up = (w_nxt == LIFTING)  & ~CIB;
  assign w_move_dn = (w_nxt == LOWERING) & ~CIB;

  for (genvar i = 0; i < N_LEAVES; i++) begin : g_leaf
    drawbridge_leaf_drv u_leaf (
      .i_move_up  (w_move_up),
      .i_move_dn  (w_move_dn),
      .i_h        (H[i]),
      .i_l        (L[i]),
      .o_mup      (w_mup[i]),
      .o_mdn      (w_mdn[i]),
      .o_conflict (w_conflict[i])
    );
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state   <= FLAT;
      r_clr_cnt <= '0;
      r_mov_cnt <= '0;
      r_pb_q    <= 1'b0;
      r_mup     <= '0;
      r_mdn     <= '0;
      r_al      <= 1'b0;
      r_tfl     <= 1'b0;
      r_flt     <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_pb_q  <= PB;

      if (w_nxt != r_state) begin
        r_clr_cnt <= '0;
        r_mov_cnt <= '0;
      end else begin
        if (r_state == CLEARING) begin
          if (CIB)                        r_clr_cnt <= '0;
          else if (r_clr_cnt != CLR_LAST) r_clr_cnt <= r_clr_cnt + CLR_W'(1);
        end
        // Timer freezes while a car is on the deck.
        if ((r_state == LIFTING || r_state == LOWERING) && !CIB && r_mov_cnt != MOV_MAX)
          r_mov_cnt <= r_mov_cnt + MOV_W'(1);
      end

      r_mup <= w_mup;
      r_mdn <= w_mdn;
      r_tfl <= (w_nxt != FLAT);
      r_flt <= (w_nxt == FAULT);
      r_al  <= (w_nxt == CLEARING) || (w_nxt == FAULT) ||
               (((w_nxt == LIFTING) || (w_nxt == LOWERING)) && CIB);
    end
  end

  assign MUP = r_mup;
  assign MDN = r_mdn;
  assign AL  = r_al;
  assign TFL = r_tfl;
  assign FLT = r_flt;

endmodule
